// File: rtl/lcd_pkg.sv
// lcd_pkg: shared command masks, bus/state types and the command decode helper
// for the LCD receive sink.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_ENTRY = 8'h04;
    localparam logic [7:0] CMD_DISP  = 8'h08;
    localparam logic [7:0] CMD_SHIFT = 8'h10;
    localparam logic [7:0] CMD_FUNC  = 8'h20;
    localparam logic [7:0] CMD_CGRAM = 8'h40;
    localparam logic [7:0] CMD_DDRAM = 8'h80;

    localparam logic [7:0] CLEAR_CHAR_DEF = 8'h20;
    localparam int         ROW_LEN        = 16;
    localparam int         CELLS          = 32;

    typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_e;

    typedef struct packed {
        logic       e;
        logic       rs;
        logic       rw;
        logic [3:0] d;
    } lcd_bus_t;

    // The highest set bit of an instruction byte selects the command.
    function automatic logic [7:0] cmd_msb(input logic [7:0] b);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) m = 8'(1 << i);
        end
        return m;
    endfunction

endpackage

// File: rtl/lcd_rx_sink_if.sv
// lcd_rx_sink_if: 4-bit HD44780-style LCD bus as seen by the display; the
// writer uses the master modport, the sink the slave modport.
interface lcd_rx_sink_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] lcd_d_in;
    logic [3:0] lcd_d_out;
    logic       lcd_d_oe;

    modport master (output lcd_e, lcd_rs, lcd_rw, lcd_d_in,
                    input  lcd_d_out, lcd_d_oe);
    modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_d_in,
                    output lcd_d_out, lcd_d_oe);
endinterface

// File: rtl/lcd_nibble_rx.sv
// lcd_nibble_rx: synchronises the LCD bus, rejects short E pulses and pairs nibbles into bytes.
// With LCD_RX_READ_EN defined it also exposes the live read-cycle view and toggles phase on read falls.
module lcd_nibble_rx
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_E_HIGH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] lcd_d,
    input  logic       four_bit,
    input  logic       phase_rst,
`ifdef LCD_RX_READ_EN
    output logic       rd_cyc,
    output logic       rd_rs,
    output logic       phase_hi,
`endif
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       byte_rs
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CW = $clog2(MIN_E_HIGH + 1);

    lcd_bus_t [SS-1:0] sync_q, sync_d;
    lcd_bus_t          in_s, cur, prev_q, prev_d;
    logic [CW-1:0]     hi_cnt_q, hi_cnt_d;
    logic              phase_hi_q, phase_hi_d;
    logic [3:0]        hi_nib_q, hi_nib_d;
    logic              byte_vld_q, byte_vld_d;
    logic [7:0]        byte_data_q, byte_data_d;
    logic              byte_rs_q, byte_rs_d;
    logic              fall;

    assign cur = sync_q[SS-1];

    // Fields are sampled from the stage before the fall, i.e. while E was still high.
    always_comb begin
        in_s        = '{e: lcd_e, rs: lcd_rs, rw: lcd_rw, d: lcd_d};
        sync_d      = {sync_q[SS-2:0], in_s};
        prev_d      = cur;
        hi_cnt_d    = '0;
        phase_hi_d  = phase_hi_q;
        hi_nib_d    = hi_nib_q;
        byte_vld_d  = 1'b0;
        byte_data_d = byte_data_q;
        byte_rs_d   = byte_rs_q;

        if (cur.e) begin
            hi_cnt_d = (hi_cnt_q < CW'(MIN_E_HIGH)) ? hi_cnt_q + CW'(1) : hi_cnt_q;
        end
        fall = prev_q.e && !cur.e && (hi_cnt_q >= CW'(MIN_E_HIGH));

        if (fall && !prev_q.rw) begin
            if (!four_bit) begin
                byte_vld_d  = 1'b1;
                byte_data_d = {prev_q.d, 4'h0};
                byte_rs_d   = prev_q.rs;
                phase_hi_d  = 1'b1;
            end else if (phase_hi_q) begin
                hi_nib_d   = prev_q.d;
                phase_hi_d = 1'b0;
            end else begin
                byte_vld_d  = 1'b1;
                byte_data_d = {hi_nib_q, prev_q.d};
                byte_rs_d   = prev_q.rs;
                phase_hi_d  = 1'b1;
            end
        end
`ifdef LCD_RX_READ_EN
        else if (fall && four_bit) begin
            phase_hi_d = !phase_hi_q;
        end
`endif
        if (phase_rst) phase_hi_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q      <= '0;
            prev_q      <= '0;
            hi_cnt_q    <= '0;
            phase_hi_q  <= 1'b1;
            hi_nib_q    <= 4'h0;
            byte_vld_q  <= 1'b0;
            byte_data_q <= 8'h00;
            byte_rs_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            hi_cnt_q    <= hi_cnt_d;
            phase_hi_q  <= phase_hi_d;
            hi_nib_q    <= hi_nib_d;
            byte_vld_q  <= byte_vld_d;
            byte_data_q <= byte_data_d;
            byte_rs_q   <= byte_rs_d;
        end
    end

    assign byte_vld  = byte_vld_q;
    assign byte_data = byte_data_q;
    assign byte_rs   = byte_rs_q;

`ifdef LCD_RX_READ_EN
    assign rd_cyc   = cur.e && cur.rw;
    assign rd_rs    = cur.rs;
    assign phase_hi = phase_hi_q;
`endif

endmodule

// File: rtl/lcd_rx_sink.sv
// lcd_rx_sink: executes the LCD writer's command subset and keeps a 2x16 character mirror.
// Define LCD_RX_READ_EN to answer status read cycles on lcd_d_out/lcd_d_oe.
module lcd_rx_sink
    import lcd_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         MIN_E_HIGH  = 4,
    parameter logic [7:0] CLEAR_CHAR  = CLEAR_CHAR_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    lcd_rx_sink_if.slave bus,
    input  logic [4:0]   rd_addr,
    output logic [7:0]   rd_data,
    output logic         display_on,
    output logic         four_bit,
    output logic         busy,
    output logic         wr_strobe,
    output logic         overrun
);

    localparam int CBW = $clog2(ROW_LEN);

    state_e           state_q, state_d;
    logic [4:0]       clr_idx_q, clr_idx_d;
    logic             row_q, row_d;
    logic [CBW-1:0]   col_q, col_d;
    logic             inc_q, inc_d;
    logic             display_on_q, display_on_d;
    logic             four_bit_q, four_bit_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       rd_data_q;
    logic [7:0]       mem [CELLS];
    logic             we;
    logic [4:0]       waddr;
    logic [7:0]       wdata;
    logic             phase_rst;
    logic             byte_vld, byte_rs;
    logic [7:0]       byte_data;

`ifdef LCD_RX_READ_EN
    logic rd_cyc, rd_rs, phase_hi;
`endif

    lcd_nibble_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_E_HIGH  (MIN_E_HIGH)
    ) u_nibble_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .lcd_e     (bus.lcd_e),
        .lcd_rs    (bus.lcd_rs),
        .lcd_rw    (bus.lcd_rw),
        .lcd_d     (bus.lcd_d_in),
        .four_bit  (four_bit_q),
        .phase_rst (phase_rst),
`ifdef LCD_RX_READ_EN
        .rd_cyc    (rd_cyc),
        .rd_rs     (rd_rs),
        .phase_hi  (phase_hi),
`endif
        .byte_vld  (byte_vld),
        .byte_data (byte_data),
        .byte_rs   (byte_rs)
    );

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        row_d        = row_q;
        col_d        = col_q;
        inc_d        = inc_q;
        display_on_d = display_on_q;
        four_bit_d   = four_bit_q;
        wr_strobe_d  = 1'b0;
        overrun_d    = overrun_q;
        we           = 1'b0;
        waddr        = {row_q, col_q};
        wdata        = byte_data;
        phase_rst    = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                we        = 1'b1;
                waddr     = clr_idx_q;
                wdata     = CLEAR_CHAR;
                clr_idx_d = clr_idx_q + 5'd1;
                // Nibble pairing keeps running in rx; only the completed byte is lost.
                if (byte_vld) overrun_d = 1'b1;
                if (clr_idx_q == 5'(CELLS - 1)) begin
                    state_d = ST_IDLE;
                    row_d   = 1'b0;
                    col_d   = '0;
                    inc_d   = 1'b1;
                end
            end
            default: begin
                if (byte_vld && byte_rs) begin
                    we          = 1'b1;
                    wr_strobe_d = 1'b1;
                    col_d       = inc_q ? col_q + CBW'(1) : col_q - CBW'(1);
                end else if (byte_vld) begin
                    case (cmd_msb(byte_data))
                        CMD_DDRAM: begin
                            row_d = byte_data[6];
                            col_d = byte_data[3:0];
                        end
                        CMD_FUNC: begin
                            four_bit_d = ~byte_data[4];
                            phase_rst  = 1'b1;
                        end
                        CMD_DISP:  display_on_d = byte_data[2];
                        CMD_ENTRY: inc_d = byte_data[1];
                        CMD_HOME: begin
                            row_d = 1'b0;
                            col_d = '0;
                        end
                        CMD_CLEAR: begin
                            state_d   = ST_CLEAR;
                            clr_idx_d = 5'd0;
                        end
                        CMD_SHIFT, CMD_CGRAM: ;
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            clr_idx_q    <= 5'd0;
            row_q        <= 1'b0;
            col_q        <= '0;
            inc_q        <= 1'b1;
            display_on_q <= 1'b0;
            four_bit_q   <= 1'b0;
            wr_strobe_q  <= 1'b0;
            overrun_q    <= 1'b0;
            rd_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            row_q        <= row_d;
            col_q        <= col_d;
            inc_q        <= inc_d;
            display_on_q <= display_on_d;
            four_bit_q   <= four_bit_d;
            wr_strobe_q  <= wr_strobe_d;
            overrun_q    <= overrun_d;
            rd_data_q    <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (we && rst_n) mem[waddr] <= wdata;
    end

    assign rd_data    = rd_data_q;
    assign display_on = display_on_q;
    assign four_bit   = four_bit_q;
    assign busy       = (state_q == ST_CLEAR);
    assign wr_strobe  = wr_strobe_q;
    assign overrun    = overrun_q;

`ifdef LCD_RX_READ_EN
    // High phase reports busy plus the row bit of the address counter, low phase the column.
    always_comb begin
        bus.lcd_d_oe  = rd_cyc;
        bus.lcd_d_out = 4'h0;
        if (rd_cyc && !rd_rs) begin
            bus.lcd_d_out = phase_hi ? {busy, row_q ? 3'b100 : 3'b000} : col_q;
        end
    end
`else
    assign bus.lcd_d_oe  = 1'b0;
    assign bus.lcd_d_out = 4'h0;
`endif

endmodule

// File: tb/tb_lcd_rx_sink.sv
// tb_lcd_rx_sink: drives the 4-bit LCD bus with directed vectors; expectations are queued
// by the stimulus and compared by a monitor when the requested read-back is presented.
module tb_lcd_rx_sink;

    typedef struct {
        string      name;
        int         kind;
        logic [4:0] addr;
        logic [8:0] val;
    } exp_t;

    localparam int K_CELL   = 0;
    localparam int K_STATUS = 1;
    localparam int K_STROBE = 2;
    localparam int K_BUSY   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       display_on, four_bit, busy, wr_strobe, overrun;

    logic       rd_req   = 1'b0;
    logic       req_pend = 1'b0;
    exp_t       exp_q[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         strobe_cnt = 0;
    int         busy_cnt   = 0;
    int         last_busy  = 0;

    lcd_rx_sink_if bus();

    lcd_rx_sink dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .display_on (display_on),
        .four_bit   (four_bit),
        .busy       (busy),
        .wr_strobe  (wr_strobe),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) req_pend <= rd_req;

    // Monitor: tracks strobes and busy runs, and checks each presented read-back.
    always @(negedge clk) begin
        exp_t       e;
        logic [8:0] act;
        if (busy) begin
            busy_cnt++;
        end else if (busy_cnt != 0) begin
            last_busy = busy_cnt;
            busy_cnt  = 0;
        end
        if (wr_strobe) strobe_cnt++;
        if (req_pend) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL scoreboard_underflow: read presented with no expectation");
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_CELL:   act = {1'b0, rd_data};
                    K_STATUS: act = {bus.lcd_d_oe, bus.lcd_d_out, display_on, four_bit, busy, overrun};
                    K_STROBE: act = 9'(strobe_cnt);
                    default:  act = 9'(last_busy);
                endcase
                if (act !== e.val) begin
                    mismatched++;
                    $display("[TB] FAIL %s (addr %0d): got 0x%0h, expected 0x%0h", e.name, e.addr, act, e.val);
                end
            end
        end
    end

    task automatic applyStimulus(input logic rs, input logic rw, input logic [3:0] d,
                                 input int hi, input int lo);
        bus.lcd_rs   = rs;
        bus.lcd_rw   = rw;
        bus.lcd_d_in = d;
        bus.lcd_e    = 1'b1;
        repeat (hi) @(negedge clk);
        bus.lcd_e = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic sendByte(input logic rs, input logic [7:0] b);
        applyStimulus(rs, 1'b0, b[7:4], 6, 8);
        applyStimulus(rs, 1'b0, b[3:0], 6, 8);
    endtask

    task automatic sendByteFast(input logic rs, input logic [7:0] b);
        applyStimulus(rs, 1'b0, b[7:4], 5, 4);
        applyStimulus(rs, 1'b0, b[3:0], 5, 4);
    endtask

    // Called on a falling edge; the monitor compares one cycle later.
    task automatic checkOutput(input string name, input int kind, input logic [4:0] addr,
                               input logic [8:0] val);
        exp_t e;
        e.name  = name;
        e.kind  = kind;
        e.addr  = addr;
        e.val   = val;
        rd_addr = addr;
        rd_req  = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic checkCell(input string name, input logic [4:0] addr, input logic [7:0] val);
        checkOutput(name, K_CELL, addr, {1'b0, val});
    endtask

    task automatic waitIdle(input string name);
        logic seen = 1'b0;
        int   n;
        for (n = 0; n < 200; n++) begin
            if (busy) seen = 1'b1;
            if (seen && !busy) break;
            @(negedge clk);
        end
        if (n >= 200) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: timeout, busy seen=%0d busy now=%0d", name, seen, busy);
        end
    endtask

    initial begin
        logic [7:0] hello [5];
        int         n;
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

        rst_n        = 1'b0;
        bus.lcd_e    = 1'b0;
        bus.lcd_rs   = 1'b0;
        bus.lcd_rw   = 1'b0;
        bus.lcd_d_in = 4'h0;
        rd_addr      = 5'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        checkOutput("reset_status", K_STATUS, 5'd0, 9'h000);
        checkOutput("reset_strobes", K_STROBE, 5'd0, 9'd0);

        // Init: function set as a single 8-bit fall, then 4-bit pairs.
        applyStimulus(1'b0, 1'b0, 4'h2, 6, 8);
        sendByte(1'b0, 8'h28);
        sendByte(1'b0, 8'h0C);
        sendByte(1'b0, 8'h01);
        waitIdle("init_clear_wait");
        sendByte(1'b0, 8'h06);
        checkOutput("init_status", K_STATUS, 5'd0, 9'h00C);
        checkOutput("init_busy_len", K_BUSY, 5'd0, 9'd32);
        for (int i = 0; i < 32; i++) checkCell("init_fill", 5'(i), 8'h20);

        sendByte(1'b0, 8'h80);
        for (int i = 0; i < 5; i++) sendByte(1'b1, hello[i]);
        for (int i = 0; i < 5; i++) checkCell("hello_cell", 5'(i), hello[i]);
        checkOutput("hello_strobes", K_STROBE, 5'd0, 9'd5);
        sendByte(1'b1, 8'h21);
        checkCell("hello_col5", 5'd5, 8'h21);
        checkCell("hello_cell6_untouched", 5'd6, 8'h20);

        sendByte(1'b0, 8'hC0);
        for (int i = 0; i < 17; i++) sendByte(1'b1, 8'(8'h41 + i));
        checkCell("row1_wrap_c16", 5'd16, 8'h51);
        checkCell("row1_c17", 5'd17, 8'h42);
        checkCell("row1_c31", 5'd31, 8'h50);
        checkCell("row0_kept", 5'd0, 8'h48);
        checkOutput("row1_strobes", K_STROBE, 5'd0, 9'd23);

        sendByte(1'b0, 8'h04);
        sendByte(1'b0, 8'h80);
        sendByte(1'b1, 8'h5A);
        sendByte(1'b1, 8'h7E);
        checkCell("dec_c0", 5'd0, 8'h5A);
        checkCell("dec_wrap_c15", 5'd15, 8'h7E);
        checkOutput("dec_strobes", K_STROBE, 5'd0, 9'd25);
        sendByte(1'b0, 8'h06);

        sendByte(1'b0, 8'h01);
        sendByteFast(1'b1, 8'h55);
        waitIdle("overrun_clear_wait");
        checkOutput("overrun_status", K_STATUS, 5'd0, 9'h00D);
        checkOutput("overrun_strobes", K_STROBE, 5'd0, 9'd25);
        sendByte(1'b1, 8'h39);
        checkCell("after_clear_c0", 5'd0, 8'h39);
        checkCell("dropped_c1", 5'd1, 8'h20);

        applyStimulus(1'b1, 1'b0, 4'h7, 3, 8);
        sendByte(1'b1, 8'h42);
        checkCell("glitch_ignored_c1", 5'd1, 8'h42);
        applyStimulus(1'b1, 1'b0, 4'h4, 4, 8);
        applyStimulus(1'b1, 1'b0, 4'h3, 4, 8);
        checkCell("min_pulse_c2", 5'd2, 8'h43);
        checkOutput("final_strobes", K_STROBE, 5'd0, 9'd28);

        sendByte(1'b0, 8'h01);
        for (n = 0; n < 40; n++) begin
            if (busy) break;
            @(negedge clk);
        end
        if (n >= 40) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL midclear_start: busy never rose, busy=%0d", busy);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        checkOutput("reset_mid_clear", K_STATUS, 5'd0, 9'h000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
